// File: rtl/npu_launch_ctrl.sv
// NPU launch controller: settles the CPU request, validates and latches
// word addresses, holds the NPU enable until ack and returns a handshake.
module npu_launch_ctrl #(
  parameter int SETTLE_CYC = 3,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_npu,
  input  logic [9:0]       mat_a,
  input  logic [9:0]       mat_b,
  input  logic [9:0]       mat_c,
  input  logic             npu_ack,
  output logic             npu_en,
  output logic [7:0]       src1_addr,
  output logic [7:0]       src2_addr,
  output logic [7:0]       rd_addr,
  output logic             acquire_npu,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {
    IDLE, SETTLE, BUSY, DONE, ERR
  } state_e;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] TMR_LAST    = 16'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [7:0]       src1_q, src1_d;
  logic [7:0]       src2_q, src2_d;
  logic [7:0]       rd_q, rd_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             npu_en_q, npu_en_d;
  logic             acq_q, acq_d;
  logic             misaligned;

  assign misaligned = |{mat_a[1:0], mat_b[1:0], mat_c[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    rd_d    = rd_q;
    err_d   = err_q;
    code_d  = code_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        if (en_npu) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          code_d  = 2'b00;
        end
      end
      SETTLE: begin
        if (!en_npu) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          if (misaligned) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'b01;
          end else begin
            state_d = BUSY;
            src1_d  = mat_a[9:2];
            src2_d  = mat_b[9:2];
            rd_d    = mat_c[9:2];
            tmr_d   = 16'd0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      BUSY: begin
        if (npu_ack) begin
          state_d = DONE;
          if (done_q != '1) done_d = done_q + CNT_W'(1);
        end else if (!en_npu) begin
          state_d = ERR;
          err_d   = 1'b1;
          code_d  = 2'b11;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ERR;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      DONE, ERR: begin
        if (!en_npu) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state
    npu_en_d = (state_d == BUSY);
    acq_d    = (state_d == DONE) || (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      code_q   <= '0;
      done_q   <= '0;
      npu_en_q <= 1'b0;
      acq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      code_q   <= code_d;
      done_q   <= done_d;
      npu_en_q <= npu_en_d;
      acq_q    <= acq_d;
    end
  end

  assign npu_en      = npu_en_q;
  assign acquire_npu = acq_q;
  assign src1_addr   = src1_q;
  assign src2_addr   = src2_q;
  assign rd_addr     = rd_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign done_cnt    = done_q;

endmodule

// File: doc/npu_launch_ctrl.md
# npu_launch_ctrl

Launch controller between the CPU's NPU request and the NPU itself. It takes the CPU's level request and the byte-addressed matrix base addresses, and waits a programmable settle window so the addresses are stable. It then validates and latches the word addresses, holds the NPU enable until the NPU acknowledges, and returns a completion handshake to the CPU. It replaces the fixed three-flop delay chain in front of the NPU and adds timeout, alignment checking and a completion counter.

## Interface

Parameters:
- SETTLE_CYC, default 3: cycles `en_npu` must stay high before the addresses are sampled; legal range 1..255.
- TIMEOUT, default 4096: maximum number of BUSY cycles to wait for `npu_ack`; legal range 2..65535.
- CNT_W, default 16: width of `done_cnt`.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: reset, synchronous, active-low.
- en_npu, in, 1: CPU request level; held high until `acquire_npu` is seen.
- mat_a, in, 10: source-1 byte address.
- mat_b, in, 10: source-2 byte address.
- mat_c, in, 10: destination byte address.
- npu_ack, in, 1: NPU completion; may be a pulse or a level.
- npu_en, out, 1: NPU enable level (registered).
- src1_addr, out, 8: latched `mat_a[9:2]`.
- src2_addr, out, 8: latched `mat_b[9:2]`.
- rd_addr, out, 8: latched `mat_c[9:2]`.
- acquire_npu, out, 1: completion or error return to the CPU (registered).
- err, out, 1: last launch failed.
- err_code, out, 2: failure cause. 00 none, 01 misaligned address, 10 timeout, 11 aborted by CPU.
- done_cnt, out, CNT_W: number of successful launches; saturating.

## Operation

- Reset (rst=0 at an edge): state goes to IDLE. All outputs become 0, including address outputs, `err_code` and `done_cnt`. Reset mid-operation drops `npu_en` after that edge with no further handshake.
- IDLE: all control outputs are low. If `en_npu`=1, go to SETTLE with cnt=0 and clear `err`/`err_code`.
- SETTLE:
  - If `en_npu`=0, return to IDLE silently; no error, no NPU activity.
  - Otherwise increment cnt. At the edge where cnt==SETTLE_CYC-1, sample `mat_a/b/c`.
  - If any sampled address has bits [1:0]≠0, go to ERR with code 01; the address outputs keep their old values.
  - Otherwise latch the [9:2] fields into the address outputs, clear the timer, and go to BUSY.
- BUSY: `npu_en`=1 and the timer increments each cycle. Exits are evaluated in this priority order:
  1. `npu_ack`=1: go to DONE.
  2. `en_npu`=0: go to ERR with code 11.
  3. timer==TIMEOUT-1: go to ERR with code 10.
- DONE: `npu_en`=0 and `acquire_npu`=1. On entry, `done_cnt` increments by 1 and saturates at all-ones. Hold until `en_npu`=0, then go to IDLE.
- ERR: `npu_en`=0, `acquire_npu`=1 and `err`=1, so the CPU never hangs. Hold until `en_npu`=0, then go to IDLE. `err` and `err_code` stay valid until the next SETTLE entry.
- Address outputs are stable from BUSY entry until the next successful latch.
- Only one launch is in flight at a time. Requests are not queued.

## Timing

- `en_npu` high before edge 0 moves the block into SETTLE at edge 0. Addresses are sampled at edge SETTLE_CYC, which is edge 3 by default. `npu_en` and the address outputs are valid in the cycle after that edge.
- With the default SETTLE_CYC, `en_npu` seen at edge 0 gives `npu_en` high after edge 3. The addresses must be stable on edge 3.
- `npu_ack` sampled at edge m: `npu_en` falls and `acquire_npu` rises after edge m.
- `en_npu` sampled low at edge m+k: `acquire_npu` falls after that edge.
- Minimum request-to-request spacing is one IDLE cycle. A CPU that drops and re-raises `en_npu` immediately is seen at the IDLE edge.
- Timeout: with no ack, ERR is entered TIMEOUT cycles after BUSY entry. `npu_en` is high for exactly TIMEOUT cycles.
- If `npu_ack` and `en_npu`=0 occur on the same edge, DONE wins. `acquire_npu` is then high for one cycle and `done_cnt` increments.
- `npu_ack` arriving outside BUSY is ignored.

## Test plan

- Nominal launch: `mat_a`=0x010, `mat_b`=0x020, `mat_c`=0x030, `en_npu` raised before edge 0, `npu_ack` pulsed at edge 10.
  - `npu_en` high over cycles 4..10.
  - Address outputs 0x04/0x08/0x0C from cycle 4.
  - `acquire_npu` high from cycle 11 until `en_npu` drops.
  - `done_cnt`=1.
- Misaligned: `mat_b`=0x021.
  - `npu_en` never asserts.
  - `acquire_npu`=1, `err`=1, `err_code`=01 after edge 3.
  - `done_cnt` unchanged.
- Timeout with TIMEOUT=8 and no ack: `npu_en` high for exactly 8 cycles, then `err_code`=10 and `acquire_npu`=1.
- Aborts:
  - `en_npu` dropped at edge 1: back to IDLE with no outputs asserted.
  - `en_npu` dropped at edge 6 in BUSY: `err_code`=11 and `npu_en` low after edge 6.
- Edge cases:
  - `npu_ack` and `en_npu` falling on the same edge: DONE taken, `acquire_npu` high for one cycle.
  - `rst`=0 in BUSY: all outputs 0 after that edge, including `done_cnt`.
  - `done_cnt` at 0xFFFF stays at 0xFFFF after another success.
